// File: rtl/vip_filter_ctrl.sv
// vip_filter_ctrl: frame-level sequencer for the 3x3 window filters.
// Detects frame start on y_vs, stretches a window-flush reset, latches the
// filter mode at frame boundaries and tracks pixel/line position.
// Optional build macro: VIP_FILTER_CTRL_STAT_EN adds frame_cnt / err_cnt.
module vip_filter_ctrl #(
    parameter int COL     = 640,
    parameter int ROW     = 480,
    parameter int RST_EXT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        y_vs,
    input  logic        y_de,
    input  logic [1:0]  cfg_mode,
    output logic        win_rst_n,
    output logic [1:0]  mode_act,
    output logic [10:0] col_cnt,
    output logic [9:0]  row_cnt,
    output logic        border,
    output logic        frame_done,
    output logic        geo_err,
    output logic        busy
`ifdef VIP_FILTER_CTRL_STAT_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`endif
);

    localparam int             FW         = (RST_EXT > 1) ? $clog2(RST_EXT) : 1;
    localparam logic [FW-1:0]  FLUSH_LOAD = FW'(RST_EXT - 1);
    localparam logic [10:0]    COL_MAX    = 11'(COL);
    localparam logic [10:0]    COL_LAST   = 11'(COL - 1);
    localparam logic [9:0]     ROW_LAST   = 10'(ROW - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, ACTIVE, DONE} state_t;

    state_t        state, state_nx;
    logic          y_vs_q, y_de_q;
    logic [FW-1:0] flush_cnt, flush_cnt_nx;
    logic [1:0]    mode_nx, mode_mapped;
    logic [10:0]   col_nx;
    logic [9:0]    row_nx;
    logic          done_nx, err_ev;
    logic          vs_rise, de_fall;

    assign vs_rise     = y_vs & ~y_vs_q;
    assign de_fall     = y_de_q & ~y_de;
    assign mode_mapped = (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;

    // Border decode is combinational on the current pixel position
    assign border = y_de & (state == ACTIVE) &
                    ((col_cnt == '0) | (col_cnt == COL_LAST) |
                     (row_cnt == '0) | (row_cnt == ROW_LAST));

    // Next-state, counter and error-event decode
    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        mode_nx      = mode_act;
        col_nx       = col_cnt;
        row_nx       = row_cnt;
        done_nx      = 1'b0;
        err_ev       = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nx     = FLUSH;
                    flush_cnt_nx = FLUSH_LOAD;
                    mode_nx      = mode_mapped;
                end
            end
            FLUSH: begin
                if (y_de) err_ev = 1'b1;
                if (vs_rise) begin
                    flush_cnt_nx = FLUSH_LOAD;
                    mode_nx      = mode_mapped;
                end else if (flush_cnt == '0) begin
                    state_nx = ACTIVE;
                end else begin
                    flush_cnt_nx = flush_cnt - 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    err_ev       = 1'b1;
                    state_nx     = FLUSH;
                    flush_cnt_nx = FLUSH_LOAD;
                    mode_nx      = mode_mapped;
                    col_nx       = '0;
                    row_nx       = '0;
                end else if (y_de) begin
                    if (col_cnt == COL_MAX) err_ev = 1'b1;
                    else                    col_nx = col_cnt + 1'b1;
                end else if (de_fall) begin
                    if (col_cnt != COL_MAX) err_ev = 1'b1;
                    col_nx = '0;
                    if (row_cnt == ROW_LAST) begin
                        row_nx   = '0;
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        row_nx = row_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                col_nx = '0;
                row_nx = '0;
                if (vs_rise) begin
                    state_nx     = FLUSH;
                    flush_cnt_nx = FLUSH_LOAD;
                    mode_nx      = mode_mapped;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            y_vs_q     <= 1'b0;
            y_de_q     <= 1'b0;
            flush_cnt  <= '0;
            win_rst_n  <= 1'b1;
            mode_act   <= 2'b00;
            col_cnt    <= '0;
            row_cnt    <= '0;
            frame_done <= 1'b0;
            geo_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            y_vs_q     <= y_vs;
            y_de_q     <= y_de;
            flush_cnt  <= flush_cnt_nx;
            win_rst_n  <= (state_nx != FLUSH);
            mode_act   <= mode_nx;
            col_cnt    <= col_nx;
            row_cnt    <= row_nx;
            frame_done <= done_nx;
            geo_err    <= geo_err | err_ev;
            busy       <= (state_nx != IDLE);
        end
    end

`ifdef VIP_FILTER_CTRL_STAT_EN
    // Frame counter wraps; error counter counts every error event and saturates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (done_nx)                  frame_cnt <= frame_cnt + 1'b1;
            if (err_ev && (err_cnt != '1)) err_cnt   <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
